// File: rtl/module_transmisor_hamming.sv
// SECDED Hamming(8,4) transmitter: encodes a 4-bit word and sends it 8N1 over a UART-style line.
// Optional ERROR_INJECT_EN adds inject_mask, XORed into the captured code word.
module module_transmisor_hamming #(
  parameter int CLKS_PER_BIT = 2700
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       tx,
  output logic [7:0] codeword
`ifdef ERROR_INJECT_EN
  ,
  input  logic [7:0] inject_mask
`endif
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // Index of the result is the Hamming position; bit 0 carries overall even parity.
  function automatic logic [7:0] hamming_enc(input logic [3:0] d);
    logic [7:0] cw;
    cw[3] = d[0];
    cw[5] = d[1];
    cw[6] = d[2];
    cw[7] = d[3];
    cw[1] = d[0] ^ d[1] ^ d[3];
    cw[2] = d[0] ^ d[2] ^ d[3];
    cw[4] = d[1] ^ d[2] ^ d[3];
    cw[0] = ^cw[7:1];
    return cw;
  endfunction

  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic [7:0]        codeword_q;
  logic [7:0]        codeword_d;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              baud_last;

`ifdef ERROR_INJECT_EN
  assign codeword_d = hamming_enc(data_in) ^ inject_mask;
`else
  assign codeword_d = hamming_enc(data_in);
`endif

  assign baud_last = (baud_q == BAUD_LAST);

  // NOTE: every register below uses <= so all updates see the pre-edge values of their peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      codeword_q <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          done_q <= 1'b0;
          if (data_valid && ready_q) begin
            codeword_q <= codeword_d;
            shift_q    <= codeword_d;
            baud_q     <= '0;
            bit_q      <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          tx_q <= shift_q[0];
          if (baud_last) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          // Raised one cycle early so the registered pulse lands on the final STOP cycle.
          done_q <= (baud_q == BAUD_PRE);
          if (baud_last) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx       = tx_q;
  assign codeword = codeword_q;

endmodule
